// File: rtl/aim_pos_ctrl_pkg.sv
// Shared types and constants for the crosshair position controller.
// Build option AIM_WRAP_EN (used by the top level) makes the X axis wrap instead of saturating.
package aim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } state_t;

    localparam int BUT_DOWN  = 0;
    localparam int BUT_RIGHT = 1;
    localparam int BUT_UP    = 2;
    localparam int BUT_LEFT  = 3;

    localparam int DEF_COORD_W = 11;
    localparam int DEF_STEP_W  = 4;
    localparam int DEF_X_MIN   = 10;
    localparam int DEF_X_MAX   = 1249;
    localparam int DEF_Y_MIN   = 10;
    localparam int DEF_Y_MAX   = 765;
    localparam int DEF_X_INIT  = 640;
    localparam int DEF_Y_INIT  = 400;

    // +1 when only pos is pressed, -1 when only neg is pressed, 0 otherwise
    function automatic logic signed [1:0] net_dir(input logic pos, input logic neg);
        logic signed [1:0] d;
        d = 2'sb00;
        if (pos && !neg) d = 2'sb01;
        if (neg && !pos) d = 2'sb11;
        return d;
    endfunction

endpackage

// File: rtl/aim_pos_ctrl_if.sv
// Pad-side request signals and crosshair outputs of aim_pos_ctrl.
// master = pad/renderer side, slave = controller.
interface aim_pos_ctrl_if #(
    parameter int COORD_W = 11
);
    logic [3:0]         dir_but;
    logic               recenter;
    logic               freeze;
    logic [COORD_W-1:0] aim_x;
    logic [COORD_W-1:0] aim_y;
    logic               moving;
    logic               fast;

    modport master (
        output dir_but, recenter, freeze,
        input  aim_x, aim_y, moving, fast
    );

    modport slave (
        input  dir_but, recenter, freeze,
        output aim_x, aim_y, moving, fast
    );
endinterface

// File: rtl/aim_pos_ctrl_axis.sv
// One coordinate axis: next position from pos, net direction and step, bounded to [MIN,MAX].
// Combinational; WRAP=1 jumps to the opposite bound instead of saturating.
module aim_axis #(
    parameter int COORD_W = 11,
    parameter int STEP_W  = 4,
    parameter int MIN     = 10,
    parameter int MAX     = 1249,
    parameter bit WRAP    = 1'b0
) (
    input  logic [COORD_W-1:0] pos_i,
    input  logic signed [1:0]  dir_i,
    input  logic [STEP_W-1:0]  step_i,
    output logic [COORD_W-1:0] pos_o
);
    localparam int EW = COORD_W + 1;
    localparam logic [EW-1:0]      MIN_E = EW'(MIN);
    localparam logic [EW-1:0]      MAX_E = EW'(MAX);
    localparam logic [COORD_W-1:0] MIN_C = COORD_W'(MIN);
    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX);

    logic [EW-1:0] pos_e;
    logic [EW-1:0] step_e;
    logic [EW-1:0] inc_e;
    logic [EW-1:0] lo_lim_e;

    // one extra bit so neither pos+step nor MIN+step can wrap
    assign pos_e    = {1'b0, pos_i};
    assign step_e   = EW'(step_i);
    assign inc_e    = pos_e + step_e;
    assign lo_lim_e = MIN_E + step_e;

    always_comb begin
        pos_o = pos_i;
        if (dir_i == 2'sb01) begin
            if (inc_e > MAX_E) pos_o = WRAP ? MIN_C : MAX_C;
            else               pos_o = inc_e[COORD_W-1:0];
        end else if (dir_i == 2'sb11) begin
            if (pos_e < lo_lim_e) pos_o = WRAP ? MAX_C : MIN_C;
            else                  pos_o = pos_i - COORD_W'(step_i);
        end
    end
endmodule

// File: rtl/aim_pos_ctrl.sv
// Frame-rate crosshair controller: 4-button pad -> bounded X/Y with hold-to-accelerate FSM.
// Build option AIM_WRAP_EN: X axis wraps at its bounds, Y always saturates.
module aim_pos_ctrl
    import aim_pkg::*;
#(
    parameter int COORD_W     = DEF_COORD_W,
    parameter int STEP_W      = DEF_STEP_W,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int X_INIT      = DEF_X_INIT,
    parameter int Y_INIT      = DEF_Y_INIT,
    parameter int STEP_SLOW   = 3,
    parameter int STEP_FAST   = 6,
    parameter int HOLD_FRAMES = 30
) (
    input  logic          clk_slw,
    input  logic          rst,
    aim_pos_ctrl_if.slave bus
);
`ifdef AIM_WRAP_EN
    localparam bit X_WRAP = 1'b1;
`else
    localparam bit X_WRAP = 1'b0;
`endif

    localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = (HOLD_FRAMES > 1) ? CNT_W'(1) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]         prev_q;
    logic [COORD_W-1:0] x_q, y_q, x_nxt, y_nxt;
    logic               moving_q, fast_q, moving_d, fast_d;

    logic signed [1:0]  dx, dy;
    logic [3:0]         v;
    logic               v_zero, v_same;
    logic [STEP_W-1:0]  step;

    assign dx      = net_dir(bus.dir_but[BUT_RIGHT], bus.dir_but[BUT_LEFT]);
    assign dy      = net_dir(bus.dir_but[BUT_DOWN],  bus.dir_but[BUT_UP]);
    assign v       = {dx, dy};
    assign v_zero  = (v == 4'd0);
    assign v_same  = (v == prev_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_slw) begin
        if (rst || bus.recenter) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= '0;
            x_q      <= COORD_W'(X_INIT);
            y_q      <= COORD_W'(Y_INIT);
            moving_q <= 1'b0;
            fast_q   <= 1'b0;
        end else if (!bus.freeze) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= v;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            moving_q <= moving_d;
            fast_q   <= fast_d;
        end
    end

    // promotion fires on the edge where the saturated count reaches HOLD_FRAMES-1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!v_zero) begin
                    state_d = SLOW;
                    cnt_d   = CNT_ONE;
                end
            end
            SLOW: begin
                if (v_zero) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!v_same) begin
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_MAX) state_d = FAST;
                end
            end
            FAST: begin
                if (v_zero) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!v_same) begin
                    state_d = SLOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // a direction change out of FAST already moves at the slow rate
    always_comb begin
        step     = (state_q == FAST && v_same) ? STEP_W'(STEP_FAST) : STEP_W'(STEP_SLOW);
        moving_d = (state_d != IDLE);
        fast_d   = (state_d == FAST);
    end

    aim_axis #(
        .COORD_W(COORD_W), .STEP_W(STEP_W), .MIN(X_MIN), .MAX(X_MAX), .WRAP(X_WRAP)
    ) u_axis_x (
        .pos_i(x_q), .dir_i(dx), .step_i(step), .pos_o(x_nxt)
    );

    aim_axis #(
        .COORD_W(COORD_W), .STEP_W(STEP_W), .MIN(Y_MIN), .MAX(Y_MAX), .WRAP(1'b0)
    ) u_axis_y (
        .pos_i(y_q), .dir_i(dy), .step_i(step), .pos_o(y_nxt)
    );

    assign bus.aim_x  = x_q;
    assign bus.aim_y  = y_q;
    assign bus.moving = moving_q;
    assign bus.fast   = fast_q;
endmodule

// File: tb/tb_aim_pos_ctrl.sv
// Directed bench for aim_pos_ctrl; expected positions are hand-derived for the default parameters.
module tb_aim_pos_ctrl;

    logic clk_slw = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    aim_pos_ctrl_if #(.COORD_W(11)) bus ();

    aim_pos_ctrl u_dut (
        .clk_slw(clk_slw),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_slw = ~clk_slw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk_slw);
            #1;
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk({tag, ".x"}, 32'(bus.aim_x), 32'(ex));
        chk({tag, ".y"}, 32'(bus.aim_y), 32'(ey));
    endtask

    task automatic chk_fsm(input string tag, input logic em, input logic ef);
        chk({tag, ".moving"}, 32'(bus.moving), 32'(em));
        chk({tag, ".fast"},   32'(bus.fast),   32'(ef));
    endtask

`ifdef AIM_WRAP_EN
    localparam int X_HI_PUSH = 10;
    localparam int X_DIAG1   = 13;
    localparam int X_DIAG2   = 16;
    localparam int X_LO_PUSH = 1249;
`else
    localparam int X_HI_PUSH = 1249;
    localparam int X_DIAG1   = 1249;
    localparam int X_DIAG2   = 1249;
    localparam int X_LO_PUSH = 10;
`endif

    initial begin
        rst          = 1'b1;
        bus.dir_but  = 4'b0000;
        bus.recenter = 1'b0;
        bus.freeze   = 1'b0;

        edges(2);
        chk_pos("reset", 640, 400);
        chk_fsm("reset", 1'b0, 1'b0);
        rst = 1'b0;

        edges(5);
        chk_pos("idle", 640, 400);
        chk("idle.moving", 32'(bus.moving), 32'd0);

        // hold right: slow for 29 edges, fast from edge 29 on
        bus.dir_but = 4'b0010;
        edges(1);
        chk_pos("right1", 643, 400);
        chk_fsm("right1", 1'b1, 1'b0);
        edges(27);
        chk("right28.x", 32'(bus.aim_x), 32'd724);
        chk("right28.fast", 32'(bus.fast), 32'd0);
        edges(1);
        chk("right29.x", 32'(bus.aim_x), 32'd727);
        chk("right29.fast", 32'(bus.fast), 32'd1);
        edges(6);
        chk_pos("right35", 763, 400);

        // FAST right -> up-right drops to SLOW with a slow step
        bus.dir_but = 4'b0110;
        edges(1);
        chk_pos("upright", 766, 397);
        chk_fsm("upright", 1'b1, 1'b0);

        // left+right cancel, up still applies
        bus.dir_but = 4'b1110;
        edges(1);
        chk_pos("cancel1", 766, 394);
        edges(1);
        chk_pos("cancel2", 766, 391);

        bus.dir_but = 4'b0010;
        edges(29);
        chk_pos("refast", 853, 391);
        chk("refast.fast", 32'(bus.fast), 32'd1);

        // frozen with a different direction: prev_dir must survive
        bus.freeze  = 1'b1;
        bus.dir_but = 4'b0001;
        edges(10);
        chk_pos("frz", 853, 391);
        chk_fsm("frz", 1'b1, 1'b1);
        bus.freeze  = 1'b0;
        bus.dir_but = 4'b0010;
        edges(1);
        chk("unfrz.x", 32'(bus.aim_x), 32'd859);
        chk("unfrz.fast", 32'(bus.fast), 32'd1);

        // recenter beats freeze and motion
        bus.recenter = 1'b1;
        bus.freeze   = 1'b1;
        edges(1);
        chk_pos("recenter", 640, 400);
        chk_fsm("recenter", 1'b0, 1'b0);
        bus.recenter = 1'b0;
        bus.freeze   = 1'b0;
        bus.dir_but  = 4'b0000;
        edges(1);
        chk_pos("post_rc", 640, 400);

        // hold counter must not advance while frozen
        bus.dir_but = 4'b0010;
        edges(27);
        chk("cnt27.x", 32'(bus.aim_x), 32'd721);
        bus.freeze = 1'b1;
        edges(5);
        chk("cntfrz.x", 32'(bus.aim_x), 32'd721);
        chk("cntfrz.fast", 32'(bus.fast), 32'd0);
        bus.freeze = 1'b0;
        edges(1);
        chk("cnt28.fast", 32'(bus.fast), 32'd0);
        edges(1);
        chk("cnt29.fast", 32'(bus.fast), 32'd1);
        chk("cnt29.x", 32'(bus.aim_x), 32'd727);

        edges(87);
        chk("xmax.x", 32'(bus.aim_x), 32'd1249);
        edges(1);
        chk("xpush.x", 32'(bus.aim_x), 32'(X_HI_PUSH));
        chk("xpush.fast", 32'(bus.fast), 32'd1);

        // diagonal into the right edge keeps sliding down
        bus.dir_but = 4'b0011;
        edges(1);
        chk_pos("diag1", X_DIAG1, 403);
        chk("diag1.fast", 32'(bus.fast), 32'd0);
        edges(1);
        chk_pos("diag2", X_DIAG2, 406);

        bus.recenter = 1'b1;
        edges(1);
        chk_pos("rc2", 640, 400);
        bus.recenter = 1'b0;

        // up-left: Y clamps at the top while X keeps moving
        bus.dir_but = 4'b1100;
        edges(29);
        chk_pos("ul29", 553, 313);
        edges(51);
        chk_pos("ytop", 247, 10);
        edges(1);
        chk_pos("yslide", 241, 10);
        edges(38);
        chk_pos("xnear", 13, 10);
        edges(1);
        chk_pos("xlo", X_LO_PUSH, 10);
        chk("xlo.fast", 32'(bus.fast), 32'd1);

        bus.dir_but = 4'b0000;
        edges(1);
        chk_pos("release", X_LO_PUSH, 10);
        chk_fsm("release", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
